// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: one outstanding fetch, one-entry hold buffer, redirect handling.
// Optional misalignment fault/HALT behaviour enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redir_valid,
    input  logic [1:0]  redir_sel,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm26,
    input  logic [15:0] redir_imm16,
    input  logic [31:0] redir_reg,
    input  logic        redir_zero,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        fault_q, fault_d;
    logic        req_q, valid_q;
    logic [31:0] tgt_raw_s;
    logic [31:0] tgt_s;
    logic        misalign_s;

    function automatic logic [31:0] calc_target(
        input logic [1:0]  sel,
        input logic [31:0] pc,
        input logic [25:0] imm26,
        input logic [15:0] imm16,
        input logic [31:0] rval,
        input logic        zero
    );
        logic [31:0] p4;
        p4 = pc + 32'd4;
        case (sel)
            2'b00:   calc_target = p4;
            2'b01:   calc_target = {pc[31:28], imm26, 2'b00};
            2'b10:   calc_target = rval;
            2'b11:   calc_target = zero ? (p4 + {{14{imm16[15]}}, imm16, 2'b00}) : p4;
            default: calc_target = p4;
        endcase
    endfunction

    assign tgt_raw_s = calc_target(redir_sel, redir_pc, redir_imm26, redir_imm16,
                                   redir_reg, redir_zero);
`ifdef PC_ALIGN_CHECK_EN
    assign tgt_s      = tgt_raw_s;
    assign misalign_s = (tgt_raw_s[1:0] != 2'b00);
`else
    // Without the check, low bits are simply dropped so HALT can never be entered.
    assign tgt_s      = tgt_raw_s & 32'hFFFF_FFFC;
    assign misalign_s = 1'b0;
`endif

    // Next-state and datapath update for the fetch/hold/drain machine.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ipc_d   = ipc_q;
        tgt_d   = tgt_q;
        fault_d = fault_q;
        case (state_q)
            ST_FETCH: begin
                if (redir_valid) begin
                    if (misalign_s) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end else if (imem_ack) begin
                        addr_d = tgt_s;
                    end else begin
                        tgt_d   = tgt_s;
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    data_d  = imem_rdata;
                    ipc_d   = addr_q;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redir_valid) begin
                    if (misalign_s) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end else begin
                        addr_d  = tgt_s;
                        state_d = ST_FETCH;
                    end
                end else if (instr_ready) begin
                    addr_d  = ipc_q + 32'd4;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                // A redirect arriving with the ack still wins over the older latched target.
                if (redir_valid && misalign_s) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else if (imem_ack) begin
                    addr_d  = redir_valid ? tgt_s : tgt_q;
                    state_d = ST_FETCH;
                end else if (redir_valid) begin
                    tgt_d = tgt_s;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            addr_q  <= RESET_PC;
            data_q  <= 32'd0;
            ipc_q   <= 32'd0;
            tgt_q   <= 32'd0;
            fault_q <= 1'b0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ipc_q   <= ipc_d;
            tgt_q   <= tgt_d;
            fault_q <= fault_d;
            req_q   <= (state_d == ST_FETCH) || (state_d == ST_DRAIN);
            valid_q <= (state_d == ST_HOLD);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr_data  = data_q;
    assign instr_pc    = ipc_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expected values are hand-computed constants.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redir_valid;
    logic [1:0]  redir_sel;
    logic [31:0] redir_pc;
    logic [25:0] redir_imm26;
    logic [15:0] redir_imm16;
    logic [31:0] redir_reg;
    logic        redir_zero;
    logic        fault;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .redir_valid(redir_valid), .redir_sel(redir_sel), .redir_pc(redir_pc),
        .redir_imm26(redir_imm26), .redir_imm16(redir_imm16), .redir_reg(redir_reg),
        .redir_zero(redir_zero), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        redir_valid = 1'b0; redir_sel = 2'b00; redir_pc = 32'd0; redir_imm26 = 26'd0;
        redir_imm16 = 16'd0; redir_reg = 32'd0; redir_zero = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({imem_req, instr_valid, imem_addr, instr_data, instr_pc, fault} !==
            {1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset: req=%b valid=%b addr=%h data=%h pc=%h fault=%b, expected 1 0 00003000 0 0 0",
                     imem_req, instr_valid, imem_addr, instr_data, instr_pc, fault);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pcs [3];
        logic [31:0] words [3];
        pcs   = '{32'h3000, 32'h3004, 32'h3008};
        words = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = words[i];
            step();
            checks++;
            if ({instr_valid, imem_req, instr_pc, instr_data} !== {1'b1, 1'b0, pcs[i], words[i]}) begin
                errors++;
                $display("FAIL seq_hold%0d: valid=%b req=%b pc=%h data=%h, expected 1 0 %h %h",
                         i, instr_valid, imem_req, instr_pc, instr_data, pcs[i], words[i]);
            end
            if (i < 2) begin
                step();
                checks++;
                if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, pcs[i] + 32'd4}) begin
                    errors++;
                    $display("FAIL seq_bubble%0d: valid=%b req=%b addr=%h, expected 0 1 %h",
                             i, instr_valid, imem_req, imem_addr, pcs[i] + 32'd4);
                end
            end
        end
        imem_ack = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({instr_valid, imem_req, instr_pc, instr_data} !== {1'b1, 1'b0, 32'h3008, 32'h3333_0000}) begin
                errors++;
                $display("FAIL stall%0d: valid=%b req=%b pc=%h data=%h, expected 1 0 00003008 33330000",
                         i, instr_valid, imem_req, instr_pc, instr_data);
            end
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300C}) begin
            errors++;
            $display("FAIL stall_release: valid=%b req=%b addr=%h, expected 0 1 0000300c",
                     instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redir_hold();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0000; instr_ready = 1'b1;
        step(); step(); step();
        imem_ack = 1'b0;
        redir_valid = 1'b1; redir_sel = 2'b11; redir_pc = 32'h3004;
        redir_imm16 = 16'hFFFF; redir_zero = 1'b1;
        step();
        redir_valid = 1'b0; instr_ready = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h3004}) begin
            errors++;
            $display("FAIL redir_hold: valid=%b req=%b addr=%h, expected 0 1 00003004",
                     instr_valid, imem_req, imem_addr);
        end
        step();
        checks++;
        if ({instr_valid, imem_addr} !== {1'b0, 32'h3004}) begin
            errors++;
            $display("FAIL redir_hold_after: valid=%b addr=%h, expected 0 00003004", instr_valid, imem_addr);
        end
    endtask

    task automatic test_drain();
        imem_ack = 1'b1; imem_rdata = 32'hBBBB_0000;
        step();
        imem_ack = 1'b0; instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        redir_valid = 1'b1; redir_sel = 2'b01; redir_pc = 32'h3008; redir_imm26 = 26'h0000C00;
        step();
        redir_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h3008}) begin
                errors++;
                $display("FAIL drain_wait%0d: req=%b valid=%b addr=%h, expected 1 0 00003008",
                         i, imem_req, instr_valid, imem_addr);
            end
            if (i < 2) step();
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        checks++;
        if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h3000}) begin
            errors++;
            $display("FAIL drain_target: req=%b valid=%b addr=%h, expected 1 0 00003000",
                     imem_req, instr_valid, imem_addr);
        end
        step();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_discard: valid=%b, expected 0", instr_valid);
        end
    endtask

    task automatic test_drain_latest();
        redir_valid = 1'b1; redir_sel = 2'b10; redir_reg = 32'h5000;
        step();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h3000}) begin
            errors++;
            $display("FAIL latest_hold: req=%b addr=%h, expected 1 00003000", imem_req, imem_addr);
        end
        redir_reg = 32'h6000;
        step();
        redir_valid = 1'b0; imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++;
        if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h6000}) begin
            errors++;
            $display("FAIL latest_target: req=%b valid=%b addr=%h, expected 1 0 00006000",
                     imem_req, instr_valid, imem_addr);
        end
    endtask

    task automatic test_redir_ack_fetch();
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        redir_valid = 1'b1; redir_sel = 2'b00; redir_pc = 32'h0100;
        step();
        imem_ack = 1'b0; redir_valid = 1'b0;
        checks++;
        if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h0104}) begin
            errors++;
            $display("FAIL redir_ack_fetch: req=%b valid=%b addr=%h, expected 1 0 00000104",
                     imem_req, instr_valid, imem_addr);
        end
    endtask

    task automatic test_align();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        redir_valid = 1'b1; redir_sel = 2'b10; redir_reg = 32'h0000_3002;
        step();
        redir_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if ({fault, imem_req, instr_valid} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL align_fault: fault=%b req=%b valid=%b, expected 1 0 0", fault, imem_req, instr_valid);
        end
        redir_valid = 1'b1; redir_reg = 32'h4000;
        step();
        redir_valid = 1'b0;
        checks++;
        if ({fault, imem_req} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL align_sticky: fault=%b req=%b, expected 1 0", fault, imem_req);
        end
        do_reset();
        checks++;
        if ({fault, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h3000}) begin
            errors++;
            $display("FAIL align_reset: fault=%b req=%b addr=%h, expected 0 1 00003000", fault, imem_req, imem_addr);
        end
`else
        checks++;
        if ({fault, imem_req, instr_valid, imem_addr} !== {1'b0, 1'b1, 1'b0, 32'h3000}) begin
            errors++;
            $display("FAIL align_force: fault=%b req=%b valid=%b addr=%h, expected 0 1 0 00003000",
                     fault, imem_req, instr_valid, imem_addr);
        end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        redir_valid = 1'b1; redir_sel = 2'b10; redir_reg = 32'hFFFF_FFFC;
        step();
        redir_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_fetch: addr=%h, expected fffffffc", imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'hCCCC_0000;
        step();
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'hFFFF_FFFC, 32'hCCCC_0000}) begin
            errors++;
            $display("FAIL wrap_hold: valid=%b pc=%h data=%h, expected 1 fffffffc cccc0000",
                     instr_valid, instr_pc, instr_data);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0000}) begin
            errors++;
            $display("FAIL wrap_next: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_drain();
        redir_valid = 1'b1; redir_sel = 2'b00; redir_pc = 32'h0200;
        step();
        redir_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h3000}) begin
            errors++;
            $display("FAIL reset_drain: req=%b valid=%b addr=%h, expected 1 0 00003000",
                     imem_req, instr_valid, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'hEEEE_0000;
        step();
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h3000, 32'hEEEE_0000}) begin
            errors++;
            $display("FAIL late_ack: valid=%b pc=%h data=%h, expected 1 00003000 eeee0000",
                     instr_valid, instr_pc, instr_data);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redir_hold();
        test_drain();
        test_drain_latest();
        test_redir_ack_fetch();
        test_align();
        test_wrap();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
